// File: rtl/col_result_drain.sv
// Drains one tile column-major from the column controllers onto a tagged valid/ready stream.
// A col_read pop in cycle N is presented in N+1. A held, unaccepted beat blocks further pops.
module col_result_drain #(
  parameter int COLS     = 8,
  parameter int ROWS     = 8,
  parameter int OUTWIDTH = 32,
  localparam int CW      = $clog2(COLS),
  localparam int RW      = $clog2(ROWS)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     start,
  input  logic [COLS*OUTWIDTH-1:0] col_r,
  input  logic [COLS-1:0]          col_rvalid,
  output logic [COLS-1:0]          col_read,
  output logic [OUTWIDTH-1:0]      out_data,
  output logic [CW-1:0]            out_col,
  output logic [RW-1:0]            out_row,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_FLUSH, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cur_col;
  logic [RW-1:0]   cur_row;
  logic            take;
  logic            last;
  logic            accept;

  assign accept = out_valid & out_ready;
  assign last   = (cur_col == CW'(COLS-1)) && (cur_row == RW'(ROWS-1));
  assign busy   = (state == S_DRAIN) || (state == S_FLUSH);
  assign done   = (state == S_DONE);

  // rstn gates the pop so no column is popped while reset is asserted.
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    col_read  = '0;
    case (state)
      S_IDLE:  if (start) state_nxt = S_DRAIN;
      S_DRAIN: begin
        take = rstn & col_rvalid[cur_col] & (~out_valid | out_ready);
        if (take && last) state_nxt = S_FLUSH;
      end
      S_FLUSH: if (accept) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    col_read[cur_col] = take;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cur_col <= '0;
      cur_row <= '0;
    end else if (state == S_IDLE && start) begin
      cur_col <= '0;
      cur_row <= '0;
    end else if (take) begin
      if (cur_row == RW'(ROWS-1)) begin
        if (cur_col != CW'(COLS-1)) begin
          cur_row <= '0;
          cur_col <= cur_col + CW'(1);
        end
      end else begin
        cur_row <= cur_row + RW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_col   <= '0;
      out_row   <= '0;
    end else if (take) begin
      out_valid <= 1'b1;
      out_data  <= col_r[cur_col*OUTWIDTH +: OUTWIDTH];
      out_col   <= cur_col;
      out_row   <= cur_row;
    end else if (accept) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_col_result_drain.sv
// Directed bench for col_result_drain: column sources, expected-tag order model and beat scoreboard.
module tb_col_result_drain;
  localparam int COLS = 8;
  localparam int ROWS = 8;
  localparam int OW   = 32;
  localparam int CW   = 3;
  localparam int RW   = 3;

  typedef struct packed {
    logic [OW-1:0] d;
    logic [CW-1:0] c;
    logic [RW-1:0] r;
  } beat_t;

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic               start = 1'b0;
  logic               out_ready = 1'b0;
  logic [COLS*OW-1:0] col_r;
  logic [COLS-1:0]    col_rvalid;
  logic [COLS-1:0]    col_read;
  logic [COLS-1:0]    rv_en = '1;
  logic [OW-1:0]      out_data;
  logic [CW-1:0]      out_col;
  logic [RW-1:0]      out_row;
  logic               out_valid, busy, done;

  int    src_idx [COLS];
  beat_t sbq[$];
  int    n_vec = 0, n_err = 0;
  int    cyc_n = 0, exp_col = 0, exp_row = 0, pend_pop = -1;
  int    pops = 0, beats = 0, dones = 0;
  int    last_pop_cyc = -10, first_beat_cyc = 0, last_beat_cyc = 0, done_cyc = 0;
  bit    hold_prev = 1'b0;
  logic [OW+CW+RW-1:0] prev_beat;

  col_result_drain #(.COLS(COLS), .ROWS(ROWS), .OUTWIDTH(OW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .col_r(col_r), .col_rvalid(col_rvalid),
    .col_read(col_read), .out_data(out_data), .out_col(out_col), .out_row(out_row),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [OW-1:0] word(input int c, input int k);
    logic [OW-1:0] w;
    w = {8'hA5, c[7:0], k[15:0]};
    return w;
  endfunction

  always_comb begin
    for (int c = 0; c < COLS; c++) col_r[c*OW +: OW] = word(c, src_idx[c]);
    col_rvalid = rv_en;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  // Observe at the falling edge, then advance the sources just after the rising edge.
  task automatic cyc();
    logic [COLS-1:0] exp_rd;
    beat_t b;
    @(negedge clk);
    cyc_n++;
    if (!rstn) begin
      chk("rst_col_read", col_read, 0);
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) chk("hold_stable", {out_valid, out_data, out_col, out_row}, {1'b1, prev_beat});
      if (last_pop_cyc == cyc_n - 1) chk("latency_vld", out_valid, 1);
      if (exp_col >= COLS) begin
        chk("extra_pop", col_read, 0);
      end else begin
        exp_rd = '0;
        exp_rd[exp_col] = 1'b1;
        if (col_read != 0) begin
          chk("pop_col", col_read, exp_rd);
          chk("pop_legal", {31'd0, rv_en[exp_col] && (!out_valid || out_ready)}, 1);
          b.d = word(exp_col, src_idx[exp_col]);
          b.c = exp_col[CW-1:0];
          b.r = exp_row[RW-1:0];
          sbq.push_back(b);
          pend_pop = exp_col;
          last_pop_cyc = cyc_n;
          pops++;
          if (exp_row == ROWS-1) begin exp_row = 0; exp_col++; end
          else exp_row++;
        end else if (busy && rv_en[exp_col] && (!out_valid || out_ready)) begin
          chk("pop_missing", col_read, exp_rd);
        end
      end
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          chk("beat_unexpected", out_valid, 0);
        end else begin
          b = sbq.pop_front();
          chk("beat_data", out_data, b.d);
          chk("beat_col", out_col, b.c);
          chk("beat_row", out_row, b.r);
        end
        beats++;
        if (beats == 1) first_beat_cyc = cyc_n;
        last_beat_cyc = cyc_n;
      end
      hold_prev = out_valid && !out_ready;
      prev_beat = {out_data, out_col, out_row};
      if (done) begin dones++; done_cyc = cyc_n; end
    end
    @(posedge clk);
    #1;
    if (pend_pop >= 0) begin src_idx[pend_pop]++; pend_pop = -1; end
  endtask

  task automatic go();
    exp_col = 0; exp_row = 0; pops = 0; beats = 0; dones = 0;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic drain(input int budget, input bit poke_done);
    int n = 0;
    while (dones == 0 && n < budget) begin
      cyc();
      n++;
      start = poke_done && done;
    end
    start = 1'b0;
    repeat (3) cyc();
    chk("tile_dones", dones, 1);
    chk("tile_beats", beats, COLS*ROWS);
    chk("tile_pops", pops, COLS*ROWS);
    chk("tile_sb_empty", sbq.size(), 0);
    chk("tile_idle", {busy, out_valid}, 0);
  endtask

  task automatic wait_beats(input int n);
    int k = 0;
    while (beats < n && k < 500) begin cyc(); k++; end
    chk("wait_beats", beats, n);
  endtask

  initial begin
    int g, snap_pops, snap_beats, k;
    for (int c = 0; c < COLS; c++) src_idx[c] = 0;
    rv_en = '1; out_ready = 1'b1; rstn = 1'b0;
    repeat (2) cyc();
    chk("rst_out", {out_valid, out_data, out_col, out_row}, 0);
    chk("rst_flags", {busy, done, col_read}, 0);
    rstn = 1'b1;
    cyc();
    chk("idle_no_pop", {busy, col_read}, 0);

    // 1. baseline
    go(); g = cyc_n;
    drain(200, 1'b0);
    chk("t1_first_beat", first_beat_cyc, g + 2);
    chk("t1_back_to_back", last_beat_cyc - first_beat_cyc, COLS*ROWS - 1);
    chk("t1_done_delay", done_cyc - last_pop_cyc, 2);

    // 2. backpressure on beat (2,3)
    go(); k = 0;
    while (!(out_valid && out_col == 3'd2 && out_row == 3'd3) && k < 200) begin cyc(); k++; end
    chk("t2_reach_23", {out_valid, out_col, out_row}, {1'b1, 3'd2, 3'd3});
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t2_bp_noread", col_read, 0);
      chk("t2_bp_tag", {out_valid, out_col, out_row}, {1'b1, 3'd2, 3'd3});
    end
    out_ready = 1'b1;
    cyc();
    chk("t2_resume_24", {out_valid, out_col, out_row}, {1'b1, 3'd2, 3'd4});
    drain(200, 1'b0);

    // 3. column 1 starved
    rv_en = '1; rv_en[1] = 1'b0;
    go(); k = 0;
    while (exp_col != 1 && k < 200) begin cyc(); k++; end
    cyc();
    snap_pops = pops; snap_beats = beats;
    for (int i = 0; i < 10; i++) cyc();
    chk("t3_no_pops", pops, snap_pops);
    chk("t3_no_beats", beats, snap_beats);
    chk("t3_out_empty", out_valid, 0);
    rv_en[1] = 1'b1;
    cyc();
    chk("t3_resume_pop", pops, snap_pops + 1);
    drain(200, 1'b0);

    // 4. start while busy and during DONE
    go();
    wait_beats(20);
    start = 1'b1; cyc(); start = 1'b0;
    drain(200, 1'b1);

    // 5. reset mid-drain
    go();
    wait_beats(30);
    rstn = 1'b0;
    cyc();
    rstn = 1'b1;
    chk("t5_rst_out", {out_valid, busy, done, col_read}, 0);
    sbq.delete(); hold_prev = 1'b0;
    go();
    drain(200, 1'b0);

    // 6. random ready and per-column valid, two tiles
    for (int t = 0; t < 2; t++) begin
      go(); k = 0;
      while (dones == 0 && k < 2000) begin
        rv_en = COLS'($urandom);
        out_ready = 1'($urandom_range(0, 1));
        cyc(); k++;
      end
      rv_en = '1; out_ready = 1'b1;
      drain(50, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
